// File: rtl/shift_ser_ctrl_pkg.sv
// Shared types and constants for the shift_ser_ctrl serializer.
package shift_ser_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        PAR   = 2'd3
    } state_t;

    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register; load wins over shift.
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             bit_out
);

    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] sr_shifted;

    // The outgoing bit always sits at one end; shifting moves the next bit there.
    generate
        if (MSB_FIRST) begin : g_msb
            assign sr_shifted = {sr_reg[WIDTH-2:0], 1'b0};
            assign bit_out    = sr_reg[WIDTH-1];
        end else begin : g_lsb
            assign sr_shifted = {1'b0, sr_reg[WIDTH-1:1]};
            assign bit_out    = sr_reg[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_reg <= '0;
        end else if (load) begin
            sr_reg <= load_data;
        end else if (shift) begin
            sr_reg <= sr_shifted;
        end
    end

endmodule

// File: rtl/shift_ser_ctrl.sv
// Serializer sequencer: valid/ready word intake, shift_en-paced serial output, idle gap.
// Optional parity bit after each word when SHIFT_SER_CTRL_PARITY_EN is defined.
module shift_ser_ctrl
    import shift_ser_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_t POST_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;
    localparam logic NO_GAP = (GAP_CYCLES == 0);

    state_t          state_reg;
    logic [BW-1:0]   bit_cnt_reg;
    logic [GW-1:0]   gap_cnt_reg;
    logic            in_ready_reg;
    logic            frame_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            accept;
    logic            sr_bit;
`ifdef SHIFT_SER_CTRL_PARITY_EN
    logic            parity_reg;
`endif

    assign accept = (state_reg == IDLE) && in_valid;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (in_data),
        .shift     ((state_reg == SHIFT) && shift_en),
        .bit_out   (sr_bit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            in_ready_reg <= 1'b1;
            frame_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef SHIFT_SER_CTRL_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg    <= SHIFT;
                        bit_cnt_reg  <= '0;
                        in_ready_reg <= 1'b0;
                        frame_reg    <= 1'b1;
                        busy_reg     <= 1'b1;
`ifdef SHIFT_SER_CTRL_PARITY_EN
                        parity_reg   <= ^in_data;
`endif
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (bit_cnt_reg == BIT_LAST) begin
`ifdef SHIFT_SER_CTRL_PARITY_EN
                            state_reg    <= PAR;
`else
                            state_reg    <= POST_FRAME;
                            gap_cnt_reg  <= '0;
                            frame_reg    <= 1'b0;
                            done_reg     <= 1'b1;
                            in_ready_reg <= NO_GAP;
                            busy_reg     <= !NO_GAP;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
`ifdef SHIFT_SER_CTRL_PARITY_EN
                PAR: begin
                    if (shift_en) begin
                        state_reg    <= POST_FRAME;
                        gap_cnt_reg  <= '0;
                        frame_reg    <= 1'b0;
                        done_reg     <= 1'b1;
                        in_ready_reg <= NO_GAP;
                        busy_reg     <= !NO_GAP;
                    end
                end
`endif
                GAP: begin
                    // Gap length is fixed in clock cycles, independent of shift_en.
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg    <= IDLE;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b1;
                    frame_reg    <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        serial_out = IDLE_LEVEL;
        if (state_reg == SHIFT) begin
            serial_out = sr_bit;
        end
`ifdef SHIFT_SER_CTRL_PARITY_EN
        if (state_reg == PAR) begin
            serial_out = parity_reg;
        end
`endif
    end

    assign in_ready = in_ready_reg;
    assign frame    = frame_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: doc/shift_ser_ctrl.md
Name: shift_ser_ctrl

Overview:
Sequencer for a parallel-in/serial-out shift register.
- Accepts a parallel word over a valid/ready handshake.
- Loads the word into the shift register and clocks it out one bit per enabled cycle.
- Inserts a programmable idle gap between frames.
- Flags frame activity and completion.
- Sits between a word producer and a single-wire serial link.

Parameters:
WIDTH, 4, data word width in bits (>= 2)
GAP_CYCLES, 1, idle cycles forced between frames (>= 0)
MSB_FIRST, 1, 1 = transmit MSB first, 0 = LSB first

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
in_valid  input  1  producer has a word on in_data
in_ready  output  1  controller can accept a word
in_data  input  WIDTH  parallel word
shift_en  input  1  advance one bit this cycle; low = hold current bit
serial_out  output  1  serial data; idle level 0
frame  output  1  high while a frame bit is driven on serial_out
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after a frame completes

Behaviour:
- Clock and reset: single clock domain. reset=0 sampled at a clk edge forces the following:
  - state=IDLE, serial_out=0, frame=0, done=0, busy=0, counters=0.
  - Any in-flight word is discarded, and no done pulse is issued for it.
- FSM states: IDLE, SHIFT, GAP (plus PAR with the optional feature).
- IDLE:
  - in_ready=1.
  - Accept occurs on an edge with in_valid=1. The word is loaded into the shift register, bit_cnt is set to 0, and the FSM moves to SHIFT.
  - shift_en is ignored in IDLE.
- SHIFT:
  - in_ready=0, frame=1, busy=1.
  - serial_out shows the current bit: in_data[WIDTH-1] first when MSB_FIRST=1, in_data[0] first otherwise.
  - On an edge with shift_en=1:
    - If bit_cnt < WIDTH-1: shift and increment bit_cnt.
    - If bit_cnt == WIDTH-1: go to GAP, or to IDLE when GAP_CYCLES=0, and set done=1 for exactly that next cycle.
  - shift_en=0 holds serial_out and bit_cnt unchanged, indefinitely.
- GAP:
  - serial_out=0, frame=0, busy=1, in_ready=0.
  - The gap counter counts GAP_CYCLES cycles unconditionally (not gated by shift_en), then the FSM goes to IDLE.
- Latency: accept at edge T gives first bit valid during cycle T+1. With shift_en held high:
  - last data bit during T+WIDTH;
  - done during T+WIDTH+1;
  - next accept possible at edge T+WIDTH+GAP_CYCLES+1.
- Counter widths: bit_cnt is $clog2(WIDTH) bits; the gap counter is $clog2(GAP_CYCLES+1) bits. bit_cnt never wraps, because the FSM leaves SHIFT at WIDTH-1.
- Boundary conditions:
  - in_valid arriving while busy is not accepted; the producer must hold it.
  - reset has priority over every other event in the same cycle.
  - in_data is sampled only on the accept edge; later changes have no effect.

Optional Feature:
Macro: SHIFT_SER_CTRL_PARITY_EN
- Defined: after the last data bit the FSM enters PAR for one shift_en-qualified bit time.
  - serial_out = even parity (XOR reduction of the accepted word), frame=1.
  - shift_en stalls PAR exactly as in SHIFT.
  - done is asserted on leaving PAR instead of leaving SHIFT, and all later timing shifts by +1 bit time.
- Undefined: the PAR state, its logic and its parity register are absent, and behaviour is exactly as described in Behaviour.

Decomposition:
- Package shift_ser_ctrl_pkg:
  - state enum typedef (IDLE, SHIFT, GAP, PAR);
  - constant IDLE_LEVEL=1'b0.
- Sub-module piso_shift_reg (parameters WIDTH, MSB_FIRST):
  - ports clk, reset, load, load_data, shift, bit_out;
  - load has priority over shift.
- The controller holds the FSM, the counters and the handshake logic.

Test Plan:
All scenarios use WIDTH=4, GAP_CYCLES=1, MSB_FIRST=1 unless noted.
1. Hold reset=0 for 2 cycles, then release -> in_ready=1, serial_out=0, frame=0, busy=0, done=0.
2. Accept 4'b1011 at T with shift_en=1 -> serial_out 1,0,1,1 in cycles T+1..T+4, frame high exactly 4 cycles, done pulse in T+5, in_ready=1 again in T+6.
3. Same word, shift_en=0 for 3 cycles during the 2nd bit -> the 0 bit is held for 4 cycles, frame stays high, all 4 bits are sent in order, done is delayed by 3 cycles.
4. in_valid held high with 4'hA then 4'h5 -> the two accepts are exactly 6 cycles apart, output stream is 1,0,1,0 then 0,1,0,1, in_ready=0 between accepts.
5. reset=0 for one cycle after 2 bits of 4'hF are sent -> the next cycle shows IDLE, serial_out=0, frame=0, no done pulse; a following 4'h3 is sent cleanly as 0,0,1,1.
6. With SHIFT_SER_CTRL_PARITY_EN defined, accept 4'b1011 -> 5 frame bits 1,0,1,1,1, done in T+6.
